mod_n_event_fsm: RTL and testbench

- Parametrised Moore event-counting state machine: advances one state per qualified input event and wraps modulo N.
- Successor to the fixed 3-state input counter, adding:
  - configurable modulus and output state,
  - level or rising-edge counting,
  - up/down direction,
  - synchronous clear and a registered wrap pulse.
- Sits as a sequence or event divider between a sampled control input and downstream control logic.

---
 rtl/mod_n_event_fsm.sv | 83 ++++++++
 tb/tb_mod_n_event_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mod_n_event_fsm.sv
// Moore modulo-N event counter: level/edge event qualification, up/down, clear and wrap pulse.
// Optional saturating wrap counter on wrap_cnt when WRAP_CNT_EN is defined.
module mod_n_event_fsm #(
    parameter int N   = 3,
    parameter int HIT = N - 1,
    parameter int W   = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in,
    input  logic         mode,
    input  logic         dir,
    input  logic         clr,
    output logic [W-1:0] state,
    output logic         out,
    output logic         wrap,
    output logic [7:0]   wrap_cnt
);

    localparam logic [W-1:0] LAST  = W'(N - 1);
    localparam logic [W-1:0] HIT_S = W'(HIT);
    localparam logic [W:0]   N_EXT = (W + 1)'(N);

    logic         in_q;
    logic         ev;
    logic         adv;
    logic         illegal;
    logic         wrap_nx;
    logic [W-1:0] state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            in_q  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            in_q  <= in;
            wrap  <= wrap_nx;
        end
    end

    // Out-of-range state recovers to 0 ahead of every other input.
    always_comb begin
        ev       = mode ? (in & ~in_q) : in;
        adv      = en & ev;
        illegal  = ({1'b0, state} >= N_EXT);
        state_nx = state;
        wrap_nx  = 1'b0;
        if (illegal || clr) begin
            state_nx = '0;
        end else if (adv && dir) begin
            wrap_nx  = (state == LAST);
            state_nx = (state == LAST) ? '0 : state + 1'b1;
        end else if (adv) begin
            wrap_nx  = (state == '0);
            state_nx = (state == '0) ? LAST : state - 1'b1;
        end
    end

    always_comb begin
        out = (state == HIT_S);
    end

`ifdef WRAP_CNT_EN
    logic [7:0] cnt_q;

    // Counts on the same edge that registers the wrap pulse.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= 8'd0;
        end else if (wrap_nx && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign wrap_cnt = cnt_q;
`else
    assign wrap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mod_n_event_fsm.sv
// Scoreboard bench for mod_n_event_fsm: three instances (N=3/HIT=2, N=5/HIT=4, N=2/HIT=1) share stimulus.
module tb_mod_n_event_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, in, mode, dir, clr;
    logic [1:0] state0;
    logic [2:0] state1;
    logic [0:0] state2;
    logic       out0, out1, out2;
    logic       wrap0, wrap1, wrap2;
    logic [7:0] cnt0, cnt1, cnt2;

    mod_n_event_fsm u_dut0 (
        .clk(clk), .rst(rst), .en(en), .in(in), .mode(mode), .dir(dir), .clr(clr),
        .state(state0), .out(out0), .wrap(wrap0), .wrap_cnt(cnt0)
    );

    mod_n_event_fsm #(.N(5), .HIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .in(in), .mode(mode), .dir(dir), .clr(clr),
        .state(state1), .out(out1), .wrap(wrap1), .wrap_cnt(cnt1)
    );

    mod_n_event_fsm #(.N(2), .HIT(1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .in(in), .mode(mode), .dir(dir), .clr(clr),
        .state(state2), .out(out2), .wrap(wrap2), .wrap_cnt(cnt2)
    );

    typedef struct packed {
        logic [7:0] st;
        logic       o;
        logic       w;
        logic [7:0] c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_tot  = 0;
    int n_pass = 0;

    // Reference model: plain integer modulo arithmetic per configuration.
    int mod_n[3] = '{3, 5, 2};
    int hit[3]   = '{2, 4, 1};
    int ms[3]    = '{0, 0, 0};
    int mc[3]    = '{0, 0, 0};
    bit mw[3]    = '{0, 0, 0};
    bit mprev    = 1'b0;
    int wraps_seen = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    endtask

    task automatic step(input bit r, input bit e, input bit i, input bit m, input bit d, input bit c);
        bit   evt;
        bit   advance;
        exp_t x;
        @(negedge clk);
        rst = r; en = e; in = i; mode = m; dir = d; clr = c;
        evt     = m ? (i && !mprev) : i;
        advance = e && evt;
        for (int k = 0; k < 3; k++) begin
            if (r || c) begin
                ms[k] = 0;
                mw[k] = 1'b0;
                mc[k] = 0;
            end else if (advance) begin
                if (d) begin
                    mw[k] = (ms[k] == mod_n[k] - 1);
                    ms[k] = (ms[k] + 1) % mod_n[k];
                end else begin
                    mw[k] = (ms[k] == 0);
                    ms[k] = (ms[k] + mod_n[k] - 1) % mod_n[k];
                end
            end else begin
                mw[k] = 1'b0;
            end
`ifdef WRAP_CNT_EN
            if (mw[k] && mc[k] < 255) mc[k] = mc[k] + 1;
`else
            mc[k] = 0;
`endif
            if (k == 0 && mw[k]) wraps_seen++;
            x.st = 8'(ms[k]);
            x.o  = (ms[k] == hit[k]);
            x.w  = mw[k];
            x.c  = 8'(mc[k]);
            if (k == 0) q0.push_back(x);
            else if (k == 1) q1.push_back(x);
            else q2.push_back(x);
        end
        mprev = r ? 1'b0 : i;
    endtask

    // Monitor: outputs are presented every cycle; compare 1 time unit after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                chk("n3.state", {6'd0, state0}, x.st);
                chk("n3.out", {7'd0, out0}, {7'd0, x.o});
                chk("n3.wrap", {7'd0, wrap0}, {7'd0, x.w});
                chk("n3.wrap_cnt", cnt0, x.c);
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                chk("n5.state", {5'd0, state1}, x.st);
                chk("n5.out", {7'd0, out1}, {7'd0, x.o});
                chk("n5.wrap", {7'd0, wrap1}, {7'd0, x.w});
                chk("n5.wrap_cnt", cnt1, x.c);
            end
            if (q2.size() > 0) begin
                x = q2.pop_front();
                chk("n2.state", {7'd0, state2}, x.st);
                chk("n2.out", {7'd0, out2}, {7'd0, x.o});
                chk("n2.wrap", {7'd0, wrap2}, {7'd0, x.w});
                chk("n2.wrap_cnt", cnt2, x.c);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; in = 1'b0; mode = 1'b0; dir = 1'b1; clr = 1'b0;

        // Reset then level count up.
        step(1, 1, 0, 0, 1, 0);
        repeat (6) step(0, 1, 1, 0, 1, 0);

        // Edge mode: high 5, low 1, high 1 -> two advances.
        step(1, 1, 1, 1, 1, 0);
        repeat (5) step(0, 1, 1, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 1, 1, 1, 0);

        // Mode switch 0->1 while in is high yields no event.
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 1, 0);

        // Down count in level mode.
        step(1, 1, 0, 0, 0, 0);
        repeat (6) step(0, 1, 1, 0, 0, 0);

        // Clear beats a simultaneous event; enable low holds state.
        step(1, 1, 0, 0, 1, 0);
        repeat (2) step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 1);
        repeat (4) step(0, 0, 1, 0, 1, 0);

        // Direction change mid-sequence.
        repeat (2) step(0, 1, 1, 0, 1, 0);
        repeat (3) step(0, 1, 1, 0, 0, 0);

        // Mid-operation reset, then edge mode with in still high.
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 1, 0);
        repeat (3) step(0, 1, 1, 1, 1, 0);

        // Long level up count: drives wrap_cnt to saturation when built.
        step(1, 1, 0, 0, 1, 0);
        repeat (600) step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 1);
        repeat (3) step(0, 1, 1, 0, 1, 0);

        // Randomised stimulus.
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 7) != 0,
                 1'($urandom_range(0, 1)),
                 ((n / 40) % 2) == 1,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < 4);
        end

        step(0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        n_tot++;
        if ((q0.size() + q1.size() + q2.size()) == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
        n_tot++;
        if (wraps_seen > 200) n_pass++;
        else $display("FAIL wrap_coverage: got %0d wraps expected >200", wraps_seen);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
